// File: rtl/key_step_ctrl.sv
// key_step_ctrl: debounced single-cycle step pulse from an active-low key.
// Optional auto-step mode enabled by defining KEY_STEP_AUTO_RUN_EN.
module key_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned RUN_DIV         = 12500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Key_n,
  input  logic        Run_Sw,
  output logic        Step,
  output logic        Pressed,
  output logic [15:0] StepCount
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q;
  logic             key_s1_q;
  logic             key_s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_hit;
  logic             step_q;
  logic             pressed_q;
  logic [15:0]      count_q;
  logic             auto_on;
  logic             tick;

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign cnt_hit = (cnt_d == CNT_LAST);

`ifdef KEY_STEP_AUTO_RUN_EN
  localparam int unsigned PRE_W =
    (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(RUN_DIV - 1);

  logic             run_s1_q;
  logic             run_s2_q;
  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      pre_q    <= '0;
    end else begin
      run_s1_q <= Run_Sw;
      run_s2_q <= run_s1_q;
      if (!run_s2_q || pre_q == PRE_LAST) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  assign auto_on = run_s2_q;
  assign tick    = run_s2_q && (pre_q == PRE_LAST);
`else
  logic unused_run;
  assign unused_run = Run_Sw;
  assign auto_on    = 1'b0;
  assign tick       = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      key_s1_q <= Key_n;
      key_s2_q <= key_s1_q;
      step_q   <= tick;
      if (step_q) begin
        count_q <= count_q + 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!key_s2_q) begin
            state_q <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (key_s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_hit) begin
            state_q   <= HELD;
            cnt_q     <= '0;
            pressed_q <= 1'b1;
            // in auto mode the prescaler owns Step
            if (!auto_on) begin
              step_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HELD: begin
          cnt_q <= '0;
          if (key_s2_q) begin
            state_q <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_hit) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Step      = step_q;
  assign Pressed   = pressed_q;
  assign StepCount = count_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb_key_step_ctrl: vector table, directed timing and random key
// traffic against a run-length debounce model.
module tb_key_step_ctrl;

  localparam int D  = 4;
  localparam int RD = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        key_n  = 1'b1;
  logic        run_sw = 1'b0;
  logic        step;
  logic        pressed;
  logic [15:0] cnt;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .RUN_DIV(RD)
  ) dut (
    .Clk(clk),
    .Reset(rst_n),
    .Key_n(key_n),
    .Run_Sw(run_sw),
    .Step(step),
    .Pressed(pressed),
    .StepCount(cnt)
  );

  always #5 clk = ~clk;

  // Model: key level seen 2 clocks late; a level differing from the
  // accepted one for D consecutive clocks is accepted.
  logic        kd1    = 1'b1;
  logic        kd2    = 1'b1;
  logic        lvl    = 1'b0;
  logic        m_step = 1'b0;
  int          run    = 0;
  logic [15:0] m_cnt  = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kd1 = 1'b1; kd2 = 1'b1; lvl = 1'b0;
      m_step = 1'b0; run = 0; m_cnt = 16'd0;
    end else begin
      if (m_step) m_cnt = m_cnt + 16'd1;
      m_step = 1'b0;
      if ((!kd2) != lvl) begin
        run++;
        if (run == D) begin
          lvl = !lvl;
          run = 0;
          m_step = lvl;
        end
      end else begin
        run = 0;
      end
      kd2 = kd1;
      kd1 = key_n;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      if (chk_en) begin
        chk("step", step, m_step);
        chk("pressed", pressed, lvl);
        chk("count", cnt, m_cnt);
      end
    end
  endtask

  task automatic wait_step(int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (step) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic        key;
    int          cycles;
    logic        exp_p;
    logic [15:0] exp_c;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int np;
    int last;
    tbl[0] = '{1'b1, 20, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 20, 1'b1, 16'd1};
    tbl[2] = '{1'b1, 10, 1'b0, 16'd1};
    tbl[3] = '{1'b0,  2, 1'b0, 16'd1};
    tbl[4] = '{1'b1,  1, 1'b0, 16'd1};
    tbl[5] = '{1'b0,  2, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 10, 1'b1, 16'd2};
    tbl[7] = '{1'b1, 10, 1'b0, 16'd2};

    #2 rst_n = 1'b0;
    cyc(2);
    chk("rst_step", step, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_count", cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      key_n = tbl[i].key;
      cyc(tbl[i].cycles);
      chk($sformatf("tbl%0d_pressed", i), pressed, tbl[i].exp_p);
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_c);
    end

    key_n = 1'b0;
    wait_step(50, k);
    chk("press_latency", k, 6);
    chk("pressed_with_step", pressed, 1);
    cyc(1);
    chk("step_single", step, 0);
    chk("count_after_step", cnt, 3);
    cyc(30);
    key_n = 1'b1;
    cyc(20);

    for (int i = 0; i < 10; i++) begin
      key_n = 1'b0; cyc(10);
      key_n = 1'b1; cyc(10);
    end
    chk("ten_presses", cnt, 13);

    force dut.count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cyc(1);
    release dut.count_q;
    cyc(2);
    chk("preload", cnt, 16'hFFFF);
    key_n = 1'b0; cyc(10);
    key_n = 1'b1; cyc(10);
    chk("wrap", cnt, 16'h0000);

    key_n = 1'b0;
    cyc(3);
    chk("no_step_pre_rst", cnt, 0);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_pressed", pressed, 0);
    rst_n = 1'b1;
    wait_step(50, k);
    chk("post_rst_latency", k, 6);
    cyc(1);
    chk("post_rst_count", cnt, 1);
    key_n = 1'b1;
    cyc(20);

    for (int s = 0; s < 250; s++) begin
      key_n = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 9));
    end
    key_n = 1'b1;
    cyc(20);

`ifdef KEY_STEP_AUTO_RUN_EN
    chk_en = 1'b0;
    np = 0;
    last = -100;
    key_n = 1'b0;
    run_sw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (step) begin
        if (np > 0) chk("auto_spacing", i - last, RD);
        np++;
        last = i;
      end
    end
    chk("auto_pulses", (np >= 4 && np <= 5), 1);
    chk("auto_pressed", pressed, 1);
    run_sw = 1'b0;
    cyc(3);
    np = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (step) np++;
    end
    chk("auto_stop", np, 0);
`else
    np = 0;
    last = 0;
    run_sw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (step) np++;
    end
    chk("runsw_ignored", np + last, 0);
    run_sw = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_step_ctrl.md
Name: key_step_ctrl

Overview:
- Upstream stage of the processor lab top level: turns the raw active-low step pushbutton into a clean, single-cycle Step pulse.
- Step is used as the processor clock enable, so one press gives exactly one instruction-state advance, however much the contact bounces.
- Also keeps a 16-bit step counter for the hex display mux.
- Optional free-running auto-step mode for demos.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable Clk cycles needed to accept a key level change (20 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RUN_DIV, 12500000, auto-step period in Clk cycles (4 Hz at 50 MHz); only used with AUTO_RUN_EN.

Ports:
- Clk  input  1  board clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- Key_n  input  1  raw pushbutton, 0 = pressed; asynchronous to Clk.
- Run_Sw  input  1  auto-run select, 1 = auto-step (AUTO_RUN_EN only; otherwise ignored).
- Step  output  1  one-Clk-cycle pulse per accepted step.
- Pressed  output  1  debounced key level, 1 = held.
- StepCount  output  16  number of Step pulses since reset, wraps.

Behaviour:
- Reset (Reset=0, async) sets:
  - Step=0, Pressed=0, StepCount=0.
  - Synchronizer flops=1 (released); debounce counter=0; FSM=IDLE; auto-run prescaler=0.
- Synchronizer: two-flop chain on Key_n; only the second flop output (ks) is used. ks lags Key_n by 2 cycles.
- FSM states and transitions:
  - IDLE: counter=0. If ks=0, go to PRESS_WAIT.
  - PRESS_WAIT: if ks=1, go to IDLE and clear the counter (bounce). Otherwise increment the counter; when it reaches DEBOUNCE_CYCLES-1, go to HELD and assert Step for that one cycle.
  - HELD: Pressed=1; counter=0. If ks=1, go to RELEASE_WAIT.
  - RELEASE_WAIT: Pressed=1. If ks=0, go to HELD and clear the counter. Otherwise increment; when it reaches DEBOUNCE_CYCLES-1, go to IDLE with Pressed=0.
- Step and Pressed are registered outputs.
- Timing:
  - First Step cycle comes DEBOUNCE_CYCLES+2 cycles after a clean falling edge of Key_n.
  - Pressed rises on the same edge as Step.
  - Pressed falls DEBOUNCE_CYCLES+2 cycles after a clean rising edge of Key_n.
- A hold of any length produces exactly one Step; no autorepeat.
- StepCount increments by 1 in the cycle after each Step pulse; 0xFFFF wraps to 0x0000 with no flag.
- Reset asserted mid-debounce aborts the debounce; no Step is issued. If the key is still held after Reset is released, a fresh full debounce runs and a Step is issued.
- Step is never high in two consecutive cycles.

Optional Feature:
- Macro: KEY_STEP_AUTO_RUN_EN.
- With the macro defined:
  - While Run_Sw=1, the prescaler counts 0..RUN_DIV-1; Step pulses for one cycle when it wraps.
  - Manual steps are suppressed. The FSM and Pressed still track the key.
  - Run_Sw 1->0 clears the prescaler immediately and returns to manual stepping.
  - Run_Sw 0->1 starts from prescaler=0, so the first auto Step comes RUN_DIV cycles later.
  - Run_Sw is synchronized through two flops.
- Without the macro: Run_Sw is unused, there is no prescaler logic, and behaviour is manual only.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and RUN_DIV=8.
1. Reset released, Key_n=1 held 20 cycles -> Step=0, Pressed=0, StepCount=0 throughout.
2. Key_n 1->0 clean, held 20 cycles -> exactly one Step pulse 6 cycles after the edge; Pressed=1 from that cycle; StepCount=1.
3. Key_n low 2 cycles, high 1, low 2, then stays low -> no Step during the bounce; a single Step 6 cycles after the last falling edge; StepCount=1.
4. Ten clean press/release pairs, each phase 10 cycles -> 10 Step pulses; StepCount=10. Preload 0xFFFF via 65535 fast presses (or force) and press once more -> StepCount=0x0000.
5. Key_n low 3 cycles, then Reset=0 for 1 cycle, key still held -> no Step before reset; after Reset=1, a Step 6 cycles later; StepCount=1.
6. KEY_STEP_AUTO_RUN_EN defined, Run_Sw=1 for 40 cycles with Key_n pressed -> Step every 8 cycles (4 or 5 pulses after sync), no extra manual Step; Run_Sw=0 -> pulses stop within 3 cycles.
